// File: rtl/dds_pkg.sv
// Shared definitions for the DDS generator, wave meter and benches.
package dds_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int CNT_W_DEF  = 20;

    // Midscale code of an unsigned DATA_W-bit sample.
    function automatic int unsigned mid_code(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    typedef enum logic {
        SEEK = 1'b0,
        MEAS = 1'b1
    } meas_state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0]  period;
        logic [DATA_W_DEF-1:0] vmin;
        logic [DATA_W_DEF-1:0] vmax;
        logic                  overflow;
    } meas_t;

endpackage

// File: rtl/dds_cross_detect.sv
// Rising midscale crossing detector with hysteresis below midscale.
module dds_cross_detect
    import dds_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int HYST   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              rise
);

    localparam logic [DATA_W-1:0] MID = DATA_W'(mid_code(DATA_W));
    localparam logic [DATA_W-1:0] LOW = MID - DATA_W'(HYST);

    logic armed;

    assign rise = sample_valid & armed & (sample >= MID);

    // Arm below the hysteresis threshold, disarm on the crossing sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (sample_valid) begin
            if (sample < LOW) begin
                armed <= 1'b1;
            end else if (rise) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dds_wave_meter.sv
// Period / min / max meter over rising midscale crossings of a sample stream.
//
// state | meaning
// SEEK  | waiting for the first crossing, no window open
// MEAS  | window open; each crossing closes it and opens the next
module dds_wave_meter
    import dds_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int HYST   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              meas_valid,
    input  logic              meas_ready,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vmax,
    output logic              overflow,
    output logic              dropped,
    output logic              locked
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meas_state_t       state, state_nx;
    logic              rise;
    logic              close_win;
    logic              handshake;
    logic              load;
    logic              discard;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] cur_min, cur_max;
    logic              cur_ovf;

    dds_cross_detect #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_cross (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .rise         (rise)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEEK;
        else     state <= state_nx;
    end

    // Next state; a crossing in MEAS closes the current window.
    always_comb begin
        state_nx  = state;
        close_win = 1'b0;
        case (state)
            SEEK:    if (rise) state_nx = MEAS;
            MEAS:    close_win = rise;
            default: state_nx = SEEK;
        endcase
    end

    assign locked    = (state == MEAS);
    assign handshake = meas_valid & meas_ready;
    assign load      = close_win & (~meas_valid | meas_ready);
    assign discard   = close_win & ~load;

    // Window trackers: a crossing restarts them with the crossing sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            cur_min <= '0;
            cur_max <= '0;
            cur_ovf <= 1'b0;
        end else if (sample_valid) begin
            if (rise) begin
                cnt     <= CNT_W'(1);
                cur_min <= sample;
                cur_max <= sample;
                cur_ovf <= 1'b0;
            end else if (state == MEAS) begin
                if (cnt == CNT_MAX) cur_ovf <= 1'b1;
                else                cnt     <= cnt + CNT_W'(1);
                if (sample < cur_min) cur_min <= sample;
                if (sample > cur_max) cur_max <= sample;
            end
        end
    end

    // Result register, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_valid <= 1'b0;
            period     <= '0;
            vmin       <= '0;
            vmax       <= '0;
            overflow   <= 1'b0;
        end else if (load) begin
            meas_valid <= 1'b1;
            period     <= cnt;
            vmin       <= cur_min;
            vmax       <= cur_max;
            overflow   <= cur_ovf;
        end else if (handshake) begin
            meas_valid <= 1'b0;
        end
    end

    // Sticky discard flag, cleared by a clean handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            dropped <= 1'b0;
        else if (discard)   dropped <= 1'b1;
        else if (handshake) dropped <= 1'b0;
    end

endmodule

// File: tb/tb_dds_wave_meter.sv
// Bench for dds_wave_meter: directed tone patterns plus random triangles,
// checked every cycle against a window-list reference model.
module tb_dds_wave_meter;
    import dds_pkg::*;

    localparam int DW     = 10;
    localparam int CW     = 20;
    localparam int CW8    = 8;
    localparam int HY     = 16;
    localparam int MIDV   = 1 << (DW - 1);
    localparam int LOWV   = MIDV - HY;
    localparam int CMAX   = (1 << CW) - 1;
    localparam int CMAX8  = (1 << CW8) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid;
    logic [DW-1:0] sample;
    logic          meas_ready;

    logic          meas_valid, overflow, dropped, locked;
    logic [CW-1:0] period;
    logic [DW-1:0] vmin, vmax;

    logic           meas_valid8, overflow8, dropped8, locked8;
    logic [CW8-1:0] period8;
    logic [DW-1:0]  vmin8, vmax8;

    dds_wave_meter #(.DATA_W(DW), .CNT_W(CW), .HYST(HY)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .meas_valid   (meas_valid),
        .meas_ready   (meas_ready),
        .period       (period),
        .vmin         (vmin),
        .vmax         (vmax),
        .overflow     (overflow),
        .dropped      (dropped),
        .locked       (locked)
    );

    dds_wave_meter #(.DATA_W(DW), .CNT_W(CW8), .HYST(HY)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .meas_valid   (meas_valid8),
        .meas_ready   (meas_ready),
        .period       (period8),
        .vmin         (vmin8),
        .vmax         (vmax8),
        .overflow     (overflow8),
        .dropped      (dropped8),
        .locked       (locked8)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: list of samples in the open window.
    bit    m_armed, m_locked;
    int    win[$];
    meas_t exp_res;
    int    exp_period8;
    bit    exp_ovf8;
    bit    exp_valid, exp_dropped;

    task automatic model_reset();
        m_armed     = 1'b0;
        m_locked    = 1'b0;
        win.delete();
        exp_res     = '0;
        exp_period8 = 0;
        exp_ovf8    = 1'b0;
        exp_valid   = 1'b0;
        exp_dropped = 1'b0;
    endtask

    task automatic model_step(input bit v, input int s, input bit r);
        bit ev, hs, close;
        int len, mn, mx;
        hs    = exp_valid && r;
        ev    = v && m_armed && (s >= MIDV);
        close = ev && m_locked;
        if (v) begin
            if (s < LOWV) m_armed = 1'b1;
            else if (ev)  m_armed = 1'b0;
        end
        if (close) begin
            len = win.size();
            mn  = win[0];
            mx  = win[0];
            foreach (win[i]) begin
                if (win[i] < mn) mn = win[i];
                if (win[i] > mx) mx = win[i];
            end
            if (!exp_valid || r) begin
                exp_res.period   = CW'((len > CMAX) ? CMAX : len);
                exp_res.vmin     = DW'(mn);
                exp_res.vmax     = DW'(mx);
                exp_res.overflow = (len > CMAX);
                exp_period8      = (len > CMAX8) ? CMAX8 : len;
                exp_ovf8         = (len > CMAX8);
                exp_valid        = 1'b1;
                if (hs) exp_dropped = 1'b0;
            end else begin
                exp_dropped = 1'b1;
            end
        end else if (hs) begin
            exp_valid   = 1'b0;
            exp_dropped = 1'b0;
        end
        if (ev) begin
            win.delete();
            win.push_back(s);
            m_locked = 1'b1;
        end else if (v && m_locked) begin
            win.push_back(s);
        end
    endtask

    task automatic check_all();
        check("meas_valid", meas_valid, exp_valid);
        check("locked",     locked,     m_locked);
        check("dropped",    dropped,    exp_dropped);
        check("period",     period,     exp_res.period);
        check("vmin",       vmin,       exp_res.vmin);
        check("vmax",       vmax,       exp_res.vmax);
        check("overflow",   overflow,   exp_res.overflow);
        check("valid8",     meas_valid8, exp_valid);
        check("period8",    period8,    exp_period8);
        check("overflow8",  overflow8,  exp_ovf8);
    endtask

    task automatic step(input bit v, input int s, input bit r);
        @(negedge clk);
        sample_valid = v;
        sample       = s[DW-1:0];
        meas_ready   = r;
        @(posedge clk);
        model_step(v, s, r);
        #1 check_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst          = 1'b1;
        sample_valid = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int saw(input int n);
        return (16 * n) % 1024;
    endfunction

    initial begin
        int n;
        int v, lo, hi, stp, dir;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        meas_ready   = 1'b0;
        #2;
        model_reset();
        check_all();
        apply_reset();

        // Sawtooth, always ready.
        for (int k = 0; k < 64 * 7; k++) step(1'b1, saw(k), 1'b1);
        check("saw_period", period, 64);
        check("saw_vmin", vmin, 0);
        check("saw_vmax", vmax, 1008);
        check("saw_ovf", overflow, 0);

        // Square with every other cycle invalid.
        apply_reset();
        for (int k = 0; k < 64 * 5; k++) begin
            step(1'b1, ((k % 64) < 32) ? 0 : 1023, 1'b1);
            step(1'b0, $urandom_range(0, 1023), 1'b1);
        end
        check("sq_period", period, 64);
        check("sq_vmin", vmin, 0);
        check("sq_vmax", vmax, 1023);

        // Stalled consumer across three crossings.
        apply_reset();
        for (int k = 0; k < 32 + 64 * 2 + 10; k++) step(1'b1, saw(k), 1'b0);
        check("stall_valid", meas_valid, 1);
        check("stall_dropped", dropped, 1);
        check("stall_period", period, 64);
        step(1'b1, saw(170), 1'b1);
        step(1'b1, saw(171), 1'b1);
        check("stall_dropped_clr", dropped, 0);
        check("stall_valid_clr", meas_valid, 0);

        // Long square saturates the narrow counter.
        apply_reset();
        for (int k = 0; k < 512 * 3 + 20; k++) step(1'b1, ((k % 512) < 256) ? 0 : 1023, 1'b1);
        check("long_period8", period8, 255);
        check("long_ovf8", overflow8, 1);
        check("long_period", period, 512);
        check("long_vmax", vmax, 1023);
        for (int k = 0; k < 64 * 3; k++) step(1'b1, saw(k), 1'b1);
        check("short_ovf8", overflow8, 0);
        check("short_period8", period8, 64);

        // Reset in the middle of a window.
        apply_reset();
        for (n = 0; n < 32 + 29; n++) step(1'b1, saw(n), 1'b1);
        apply_reset();
        check("rst_locked", locked, 0);
        check("rst_period", period, 0);
        for (; n < 32 + 29 + 64 * 3; n++) step(1'b1, saw(n), 1'b1);
        check("rst_after_period", period, 64);

        // Noisy midscale never re-arms.
        apply_reset();
        step(1'b1, 0, 1'b1);
        step(1'b1, 520, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 500, 1'b1);
            step(1'b1, 520, 1'b1);
            step(1'b1, 505, 1'b1);
            step(1'b1, 530, 1'b1);
        end
        check("noisy_valid", meas_valid, 0);
        check("noisy_locked", locked, 1);

        // Random triangles, random qualifiers and consumer stalls.
        apply_reset();
        v   = MIDV;
        dir = 1;
        lo  = 0;
        hi  = 1023;
        stp = 16;
        for (int k = 0; k < 4000; k++) begin
            if (k % 300 == 0) begin
                lo  = $urandom_range(0, 450);
                hi  = $urandom_range(560, 1023);
                stp = $urandom_range(1, 48);
            end
            v += dir * stp;
            if (v >= hi) begin
                v   = hi;
                dir = -1;
            end else if (v <= lo) begin
                v   = lo;
                dir = 1;
            end
            step($urandom_range(0, 3) != 0, v, $urandom_range(0, 1) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
